// File: rtl/alu_issue_stage.sv
// Issue register between decode and the ALU: operand B select, result forwarding,
// and a 2-entry skid buffer so in_ready is registered.
module alu_issue_stage #(
   parameter int unsigned DATA_WIDTH     = 16,
   parameter int unsigned REG_ADDR_WIDTH = 3
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      flush,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DATA_WIDTH-1:0]     in_rs_val,
   input  logic [DATA_WIDTH-1:0]     in_rt_val,
   input  logic [DATA_WIDTH-1:0]     in_imm,
   input  logic                      in_use_imm,
   input  logic [2:0]                in_alu_op,
   input  logic [REG_ADDR_WIDTH-1:0] in_rs_addr,
   input  logic [REG_ADDR_WIDTH-1:0] in_rt_addr,
   input  logic [REG_ADDR_WIDTH-1:0] in_rd_addr,
   input  logic                      in_rd_we,
   input  logic                      fwd_valid,
   input  logic [REG_ADDR_WIDTH-1:0] fwd_rd_addr,
   input  logic [DATA_WIDTH-1:0]     fwd_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DATA_WIDTH-1:0]     out_a,
   output logic [DATA_WIDTH-1:0]     out_b,
   output logic [2:0]                out_alu_op,
   output logic [REG_ADDR_WIDTH-1:0] out_rd_addr,
   output logic                      out_rd_we
);

   localparam int unsigned OP_WIDTH = 3;

   typedef struct packed {
      logic [DATA_WIDTH-1:0]     a;
      logic [DATA_WIDTH-1:0]     b;
      logic                      use_imm;
      logic [OP_WIDTH-1:0]       alu_op;
      logic [REG_ADDR_WIDTH-1:0] rs_addr;
      logic [REG_ADDR_WIDTH-1:0] rt_addr;
      logic [REG_ADDR_WIDTH-1:0] rd_addr;
      logic                      rd_we;
   } entry_t;

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_FULL  = 2'd2
   } state_t;

   state_t state_q, state_n;
   entry_t main_q, main_n;
   entry_t skid_q, skid_n;
   entry_t cap_c;
   logic   in_ready_n;
   logic   out_valid_n;
   logic   accept_c;
   logic   issue_c;

   // Replace sources that match the executing result; register 0 and immediates are never replaced.
   function automatic entry_t snoop(input entry_t e, input logic fv,
                                    input logic [REG_ADDR_WIDTH-1:0] fa,
                                    input logic [DATA_WIDTH-1:0] fd);
      entry_t r;
      r = e;
      if (fv && (fa == e.rs_addr) && (e.rs_addr != '0)) r.a = fd;
      if (!e.use_imm && fv && (fa == e.rt_addr) && (e.rt_addr != '0)) r.b = fd;
      return r;
   endfunction

   assign accept_c = in_valid & in_ready;
   assign issue_c  = out_valid & out_ready;

   always_comb begin
      cap_c         = '0;
      cap_c.a       = in_rs_val;
      cap_c.b       = in_use_imm ? in_imm : in_rt_val;
      cap_c.use_imm = in_use_imm;
      cap_c.alu_op  = in_alu_op;
      cap_c.rs_addr = in_rs_addr;
      cap_c.rt_addr = in_rt_addr;
      cap_c.rd_addr = in_rd_addr;
      cap_c.rd_we   = in_rd_we;
      cap_c         = snoop(cap_c, fwd_valid, fwd_rd_addr, fwd_data);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_EMPTY;
         main_q    <= '0;
         skid_q    <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         state_q   <= state_n;
         main_q    <= main_n;
         skid_q    <= skid_n;
         in_ready  <= in_ready_n;
         out_valid <= out_valid_n;
      end
   end

   // Next state and entry contents; held entries snoop every cycle by default.
   always_comb begin
      state_n = state_q;
      main_n  = snoop(main_q, fwd_valid, fwd_rd_addr, fwd_data);
      skid_n  = snoop(skid_q, fwd_valid, fwd_rd_addr, fwd_data);
      if (flush) begin
         state_n = S_EMPTY;
      end else begin
         unique case (state_q)
            S_EMPTY: begin
               if (accept_c) begin
                  state_n = S_ONE;
                  main_n  = cap_c;
               end
            end
            S_ONE: begin
               if (accept_c && !issue_c) begin
                  state_n = S_FULL;
                  skid_n  = cap_c;
               end else if (issue_c && !accept_c) begin
                  state_n = S_EMPTY;
               end else if (accept_c && issue_c) begin
                  main_n = cap_c;
               end
            end
            S_FULL: begin
               if (issue_c) begin
                  state_n = S_ONE;
                  main_n  = skid_n;
               end
            end
            default: state_n = S_EMPTY;
         endcase
      end
      in_ready_n  = (state_n != S_FULL);
      out_valid_n = (state_n != S_EMPTY);
   end

   assign out_a       = main_q.a;
   assign out_b       = main_q.b;
   assign out_alu_op  = main_q.alu_op;
   assign out_rd_addr = main_q.rd_addr;
   assign out_rd_we   = main_q.rd_we;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed and random bench for alu_issue_stage against a queue-based model.
module tb_alu_issue_stage;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_rs_val, in_rt_val, in_imm;
   logic        in_use_imm;
   logic [2:0]  in_alu_op;
   logic [2:0]  in_rs_addr, in_rt_addr, in_rd_addr;
   logic        in_rd_we;
   logic        fwd_valid;
   logic [2:0]  fwd_rd_addr;
   logic [15:0] fwd_data;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_a, out_b;
   logic [2:0]  out_alu_op;
   logic [2:0]  out_rd_addr;
   logic        out_rd_we;

   alu_issue_stage #(.DATA_WIDTH(16), .REG_ADDR_WIDTH(3)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_rs_val(in_rs_val), .in_rt_val(in_rt_val), .in_imm(in_imm),
      .in_use_imm(in_use_imm), .in_alu_op(in_alu_op),
      .in_rs_addr(in_rs_addr), .in_rt_addr(in_rt_addr), .in_rd_addr(in_rd_addr),
      .in_rd_we(in_rd_we),
      .fwd_valid(fwd_valid), .fwd_rd_addr(fwd_rd_addr), .fwd_data(fwd_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_a(out_a), .out_b(out_b), .out_alu_op(out_alu_op),
      .out_rd_addr(out_rd_addr), .out_rd_we(out_rd_we)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        use_imm;
      logic [2:0]  op;
      logic [2:0]  rs;
      logic [2:0]  rt;
      logic [2:0]  rd;
      logic        we;
   } ent_t;

   ent_t q[$];
   bit   m_ready;
   int   errors;
   int   checks;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit hit(input logic [2:0] src);
      return fwd_valid && (fwd_rd_addr == src) && (src != 3'd0);
   endfunction

   // One clock: update the queue model with the values present at the edge, then compare.
   task automatic step();
      ent_t c;
      bit   acc, iss;
      acc = in_valid && m_ready;
      iss = (q.size() > 0) && out_ready;
      c.use_imm = in_use_imm;
      c.op = in_alu_op; c.rs = in_rs_addr; c.rt = in_rt_addr;
      c.rd = in_rd_addr; c.we = in_rd_we;
      c.a  = hit(in_rs_addr) ? fwd_data : in_rs_val;
      if (in_use_imm)          c.b = in_imm;
      else if (hit(in_rt_addr)) c.b = fwd_data;
      else                     c.b = in_rt_val;
      @(posedge clk);
      if (!rst_n || flush) begin
         q.delete();
      end else begin
         if (iss) void'(q.pop_front());
         for (int i = 0; i < q.size(); i++) begin
            if (hit(q[i].rs)) q[i].a = fwd_data;
            if (!q[i].use_imm && hit(q[i].rt)) q[i].b = fwd_data;
         end
         if (acc) q.push_back(c);
      end
      m_ready = (q.size() < 2);
      #1;
      chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
      chk("in_ready", 32'(in_ready), 32'(m_ready));
      if (q.size() > 0) begin
         chk("out_a", 32'(out_a), 32'(q[0].a));
         chk("out_b", 32'(out_b), 32'(q[0].b));
         chk("out_alu_op", 32'(out_alu_op), 32'(q[0].op));
         chk("out_rd_addr", 32'(out_rd_addr), 32'(q[0].rd));
         chk("out_rd_we", 32'(out_rd_we), 32'(q[0].we));
      end
   endtask

   task automatic set_in(input logic [2:0] rs, input logic [15:0] rsv,
                         input logic [2:0] rt, input logic [15:0] rtv,
                         input logic [2:0] op, input logic [2:0] rd);
      in_valid = 1'b1; in_use_imm = 1'b0; in_imm = 16'h0;
      in_rs_addr = rs; in_rs_val = rsv; in_rt_addr = rt; in_rt_val = rtv;
      in_alu_op = op; in_rd_addr = rd; in_rd_we = 1'b1;
   endtask

   task automatic chk_zero_fields(input string tag);
      chk({tag, "_a"}, 32'(out_a), 32'h0);
      chk({tag, "_b"}, 32'(out_b), 32'h0);
      chk({tag, "_op"}, 32'(out_alu_op), 32'h0);
      chk({tag, "_rd"}, 32'(out_rd_addr), 32'h0);
      chk({tag, "_we"}, 32'(out_rd_we), 32'h0);
   endtask

   initial begin
      errors = 0; checks = 0; m_ready = 1'b1;
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_rs_val = '0; in_rt_val = '0; in_imm = '0; in_use_imm = 1'b0;
      in_alu_op = '0; in_rs_addr = '0; in_rt_addr = '0; in_rd_addr = '0; in_rd_we = 1'b0;
      fwd_valid = 1'b0; fwd_rd_addr = '0; fwd_data = '0;
      #2;
      step();
      chk("rst_valid", 32'(out_valid), 32'h0);
      chk("rst_ready", 32'(in_ready), 32'h1);
      chk_zero_fields("rst");
      rst_n = 1'b1;

      // basic accept and single-cycle latency
      out_ready = 1'b1;
      set_in(3'd1, 16'h0005, 3'd2, 16'h0003, 3'd0, 3'd5);
      step();
      chk("basic_a", 32'(out_a), 32'h0005);
      chk("basic_b", 32'(out_b), 32'h0003);
      in_valid = 1'b0;
      step();
      chk("basic_drain", 32'(out_valid), 32'h0);

      // immediate select, immune to forwarding
      set_in(3'd1, 16'h0001, 3'd2, 16'h1234, 3'd4, 3'd6);
      in_use_imm = 1'b1; in_imm = 16'hFFFE;
      step();
      chk("imm_b", 32'(out_b), 32'hFFFE);
      fwd_valid = 1'b1; fwd_rd_addr = 3'd2; fwd_data = 16'h7777;
      step();
      chk("imm_fwd_b", 32'(out_b), 32'hFFFE);

      // capture forwarding, including register 0
      set_in(3'd3, 16'h0011, 3'd4, 16'h0022, 3'd1, 3'd7);
      fwd_rd_addr = 3'd3; fwd_data = 16'h00AA;
      step();
      chk("cap_fwd_a", 32'(out_a), 32'h00AA);
      set_in(3'd0, 16'h0011, 3'd4, 16'h0022, 3'd1, 3'd7);
      fwd_rd_addr = 3'd0;
      step();
      chk("cap_r0_a", 32'(out_a), 32'h0011);
      in_valid = 1'b0; fwd_valid = 1'b0;
      step();

      // backpressure: A, B held; C refused; snoop into B
      out_ready = 1'b0;
      set_in(3'd1, 16'h000A, 3'd2, 16'h0001, 3'd1, 3'd1);
      step();
      set_in(3'd4, 16'h000B, 3'd2, 16'h0002, 3'd2, 3'd2);
      step();
      chk("bp_ready_low", 32'(in_ready), 32'h0);
      set_in(3'd5, 16'h000C, 3'd2, 16'h0003, 3'd3, 3'd3);
      step();
      fwd_valid = 1'b1; fwd_rd_addr = 3'd4; fwd_data = 16'h0099;
      step();
      chk("bp_hold_a", 32'(out_a), 32'h000A);
      fwd_valid = 1'b0; out_ready = 1'b1;
      step();
      chk("bp_b_a", 32'(out_a), 32'h0099);
      chk("bp_b_op", 32'(out_alu_op), 32'h2);
      chk("bp_ready_back", 32'(in_ready), 32'h1);
      step();
      chk("bp_c_a", 32'(out_a), 32'h000C);
      in_valid = 1'b0;
      step();

      // flush from FULL with a simultaneous input
      out_ready = 1'b0;
      set_in(3'd1, 16'h0101, 3'd2, 16'h0202, 3'd5, 3'd1);
      step();
      step();
      set_in(3'd1, 16'hDEAD, 3'd2, 16'hBEEF, 3'd6, 3'd2);
      flush = 1'b1;
      step();
      chk("flush_valid", 32'(out_valid), 32'h0);
      chk("flush_ready", 32'(in_ready), 32'h1);
      flush = 1'b0; in_valid = 1'b0;
      step();
      chk("flush_dropped", 32'(out_valid), 32'h0);

      // zero-bubble streaming, then reset midway
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         set_in(3'(i), 16'(16'h0100 + i), 3'(i + 1), 16'(16'h0200 + i), 3'(i), 3'(i));
         step();
         chk("stream_valid", 32'(out_valid), 32'h1);
      end
      rst_n = 1'b0;
      step();
      chk("mid_rst_valid", 32'(out_valid), 32'h0);
      chk("mid_rst_ready", 32'(in_ready), 32'h1);
      chk_zero_fields("mid_rst");
      rst_n = 1'b1; in_valid = 1'b0;
      step();

      // random traffic against the model
      for (int n = 0; n < 500; n++) begin
         in_valid    = 1'($urandom_range(0, 1));
         out_ready   = 1'($urandom_range(0, 2) != 0);
         in_rs_val   = 16'($urandom);
         in_rt_val   = 16'($urandom);
         in_imm      = 16'($urandom);
         in_use_imm  = 1'($urandom_range(0, 1));
         in_alu_op   = 3'($urandom);
         in_rs_addr  = 3'($urandom);
         in_rt_addr  = 3'($urandom);
         in_rd_addr  = 3'($urandom);
         in_rd_we    = 1'($urandom_range(0, 1));
         fwd_valid   = 1'($urandom_range(0, 1));
         fwd_rd_addr = 3'($urandom);
         fwd_data    = 16'($urandom);
         flush       = ($urandom_range(0, 24) == 0);
         rst_n       = ($urandom_range(0, 59) != 0);
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

- Pipeline register between decode and the `alu` execute stage.
- Captures decoded operands, selects register or immediate for operand B, and applies result forwarding from the instruction leaving execute.
- Presents ALU-ready `a`, `b` and `alu_op` with a valid/ready handshake.
- A 2-entry skid buffer registers `in_ready`, so there is no combinational path from `out_ready` to `in_ready`.

## Interface
- `DATA_WIDTH`, 16, operand/result width; matches the ALU.
- `REG_ADDR_WIDTH`, 3, register-address width; register 0 is hardwired zero.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: one clock; reset is synchronous and active-low.
- `flush` input 1: discard all held entries (branch/redirect).
- `in_valid` input 1: decode has an instruction.
- `in_ready` output 1: stage can accept; registered.
- `in_rs_val`, `in_rt_val` input DATA_WIDTH: register-file read data.
- `in_imm` input DATA_WIDTH: sign-extended immediate.
- `in_use_imm` input 1: operand B = `in_imm` instead of `rt`.
- `in_alu_op` input 3: ALU opcode, passed through unchanged.
- `in_rs_addr`, `in_rt_addr`, `in_rd_addr` input REG_ADDR_WIDTH: source and destination registers.
- `in_rd_we` input 1: instruction writes `rd`.
- `fwd_valid` input 1: execute result is valid this cycle and will be written.
- `fwd_rd_addr` input REG_ADDR_WIDTH, `fwd_data` input DATA_WIDTH: forwarded destination and ALU result.
- `out_valid` output 1; `out_ready` input 1: handshake toward the ALU.
- `out_a`, `out_b` output DATA_WIDTH; `out_alu_op` output 3; `out_rd_addr` output REG_ADDR_WIDTH; `out_rd_we` output 1.

## Operation
- Handshake rules:
  - Accept when `in_valid & in_ready`; issue when `out_valid & out_ready`.
  - `out_valid` and all `out_*` fields come from the main entry and are registered.
  - `out_*` fields are stable while `out_valid & !out_ready`.
- Each entry stores: a, b, use_imm, alu_op, rs/rt/rd addresses, rd_we.
- Capture forwarding:
  - a = `fwd_data` if `fwd_valid` and `fwd_rd_addr == in_rs_addr` and `in_rs_addr != 0`; otherwise `in_rs_val`.
  - b = `in_imm` if `in_use_imm`.
  - Otherwise b = `fwd_data` on the same match against `in_rt_addr`, else `in_rt_val`.
  - Source address 0 always yields the register value (zero), never forwarded data.
- Snoop forwarding:
  - Every cycle, each held entry replaces a and/or b with `fwd_data` under the same match rule.
  - b is never replaced when use_imm = 1.
  - The snoop also applies on the cycle the skid entry moves to main.
- States: EMPTY (no entry), ONE (main valid), FULL (main + skid valid).
  - EMPTY: accept -> ONE (main <= input).
  - ONE: accept only -> FULL (skid <= input); issue only -> EMPTY; accept and issue -> ONE (main <= input); neither -> ONE.
  - FULL: issue -> ONE (main <= skid); else FULL. No accept possible.
- `in_ready` = (next state != FULL), registered. `out_valid` = (state != EMPTY).
- Flush:
  - Next state is EMPTY, `in_ready` = 1, and any same-cycle input is dropped.
  - Flush has priority over accept and issue. An issue on the flush cycle still completes at the ALU.
- No arithmetic is performed here; widths pass unchanged and alu_op is not decoded.

## Timing
- Reset, sampled on a `clk` edge with `rst_n` low:
  - State EMPTY; `out_valid` = 0; `in_ready` = 1.
  - `out_a`, `out_b`, `out_rd_addr` = 0; `out_alu_op` = 3'b000; `out_rd_we` = 0.
- Reset overrides flush and handshakes. Inputs are ignored on a reset cycle, including when reset is asserted mid-operation; held entries are lost.
- Latency: accepted at edge N, `out_valid` = 1 after edge N (1 cycle). Zero-bubble throughput of 1/cycle when `out_ready` = 1.
- Backpressure: with `out_ready` low, 2 instructions are accepted, then `in_ready` = 0 after the second accept edge.
- `in_ready` returns 1 the cycle after the first issue.
- Forwarding: `fwd_*` sampled at the same edge as capture/snoop. Data forwarded at edge N is visible on `out_a`/`out_b` after edge N.

## Test plan
- Reset, then accept rs=1 (val 0x0005), rt=2 (val 0x0003), op=000, `out_ready`=1 -> next cycle `out_valid`=1, `out_a`=0x0005, `out_b`=0x0003, then `out_valid`=0.
- `in_use_imm`=1, `in_imm`=0xFFFE, rt val 0x1234 -> `out_b`=0xFFFE. Same with `fwd_rd_addr`=rt, `fwd_data`=0x7777 -> `out_b` stays 0xFFFE.
- Forwarding:
  - Capture with `fwd_valid`=1, `fwd_rd_addr`=3=`in_rs_addr`, `fwd_data`=0x00AA, `in_rs_val`=0x0011 -> `out_a`=0x00AA.
  - Same with addr 0 -> `out_a`=`in_rs_val`.
- `out_ready`=0, push 3 instructions A, B, C:
  - `in_ready` drops after B; C is not taken.
  - While held, fwd to B's rs with 0x0099 -> after releasing `out_ready`, order is A then B with `out_a`=0x0099, then C is accepted.
- FULL state, assert `flush` with `in_valid`=1 -> next cycle `out_valid`=0 and `in_ready`=1; the flushed-cycle input never appears at the output.
- Stream 8 back-to-back instructions with `out_ready`=1 -> 8 consecutive issue cycles, no bubbles. Assert `rst_n`=0 midway -> next cycle `out_valid`=0, `in_ready`=1, all `out_*` fields zero.
